// File: rtl/Uop.sv
// Shared micro-op types between decode and issue: decoded uop, issued uop,
// functional-unit selection, memory-op descriptor and exception causes.
package Uop;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned VAL_W      = 32;

    typedef logic [VAL_W-1:0]      val_t;
    typedef logic [REG_ADDR_W-1:0] reg_t;
    typedef logic [3:0]            op_t;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ALU  = 3'd1,
        FU_MUL  = 3'd2,
        FU_LSU  = 3'd3,
        FU_BR   = 3'd4
    } fu_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_sz_t;

    typedef enum logic [1:0] {
        EX_NONE    = 2'd0,
        EX_DECODE  = 2'd1,
        EX_ILLEGAL = 2'd2
    } ex_t;

    typedef struct packed {
        logic    valid;
        logic    store;
        logic    sext;
        mem_sz_t sz;
    } memop_t;

    typedef struct packed {
        fu_t    fu;
        op_t    op;
        reg_t   rd;
        reg_t   rs1;
        reg_t   rs2;
        val_t   imm;
        logic   immValid;
        memop_t memOp;
        logic   flagsValid;
        logic   exValid;
        ex_t    ex;
    } dec_t;

    typedef struct packed {
        fu_t    fu;
        op_t    op;
        val_t   a;
        val_t   b;
        val_t   stData;
        reg_t   rd;
        memop_t memOp;
        logic   flagsValid;
    } iss_t;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register,
// with a set port, a clear port, a global clear and two combinational queries.
module issue_stage_scoreboard #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_all,
    input  logic                        set_en,
    input  logic [$clog2(NUM_REGS)-1:0] set_addr,
    input  logic                        clr_en,
    input  logic [$clog2(NUM_REGS)-1:0] clr_addr,
    input  logic [$clog2(NUM_REGS)-1:0] q1_addr,
    output logic                        q1_busy,
    input  logic [$clog2(NUM_REGS)-1:0] q2_addr,
    output logic                        q2_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied before set so a same-register collision leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy = busy_q[q1_addr];
    assign q2_busy = busy_q[q2_addr];

endmodule

// File: rtl/issue_stage.sv
// Issue stage: one-deep hold slot for decoded uops, hazard check against the
// busy-bit scoreboard, operand read and an issue register towards the FUs.
module issue_stage
    import Uop::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  dec_t                        in_dec,
    output logic [$clog2(NUM_REGS)-1:0] rf_raddr1,
    output logic [$clog2(NUM_REGS)-1:0] rf_raddr2,
    input  logic [XLEN-1:0]             rf_rdata1,
    input  logic [XLEN-1:0]             rf_rdata2,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output iss_t                        iss,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        flush,
    output logic                        ex_valid,
    output ex_t                         ex_code
);

    typedef enum logic [0:0] {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    dec_t h;
    logic h_valid;
    iss_t o;
    logic o_valid;
    iss_t iss_d;

    logic go;
    logic hazard;
    logic q1_busy;
    logic q2_busy;
    logic set_en;

    assign rf_raddr1 = h.rs1;
    assign rf_raddr2 = h.rs2;

    assign hazard = ((h.rs1 != '0) && q1_busy) || ((h.rs2 != '0) && q2_busy);
    assign set_en = go && (h.fu != FU_NONE);

    issue_stage_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (flush),
        .set_en   (set_en),
        .set_addr (h.rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .q1_addr  (h.rs1),
        .q1_busy  (q1_busy),
        .q2_addr  (h.rs2),
        .q2_busy  (q2_busy)
    );

    always_comb begin
        state_d  = state_q;
        go       = 1'b0;
        in_ready = 1'b0;
        ex_valid = 1'b0;
        ex_code  = EX_NONE;
        case (state_q)
            RUN: begin
                go       = h_valid && !h.exValid && !hazard && (!o_valid || iss_ready);
                in_ready = !h_valid || go;
                if (h_valid && h.exValid) begin
                    ex_valid = 1'b1;
                    ex_code  = h.ex;
                    state_d  = EXC;
                end
            end
            EXC:     state_d = EXC;
            default: state_d = RUN;
        endcase
        if (flush) begin
            in_ready = 1'b0;
            state_d  = RUN;
        end
        if (rst) begin
            in_ready = 1'b0;
            ex_valid = 1'b0;
            ex_code  = EX_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        iss_d            = '0;
        iss_d.fu         = h.fu;
        iss_d.op         = h.op;
        iss_d.a          = rf_rdata1;
        iss_d.b          = h.immValid ? h.imm : rf_rdata2;
        iss_d.stData     = rf_rdata2;
        iss_d.rd         = h.rd;
        iss_d.memOp      = h.memOp;
        iss_d.flagsValid = h.flagsValid;
    end

    // FU_NONE uops leave H on go but never occupy O, so O may drain meanwhile.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            h       <= '0;
            h_valid <= 1'b0;
            o       <= '0;
            o_valid <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                h       <= in_dec;
                h_valid <= 1'b1;
            end else if (go) begin
                h_valid <= 1'b0;
            end
            if (go && (h.fu != FU_NONE)) begin
                o       <= iss_d;
                o_valid <= 1'b1;
            end else if (iss_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign iss_valid = o_valid && !rst;
    assign iss       = o;

endmodule
